// File: rtl/spi_accel_slave.sv
// spi_accel_slave
//   SPI mode-0 responder (MSB first) that emulates a small accelerometer.
//   Command 0x0A starts a write frame, 0x0B a read frame; the next byte is
//   the register address, and following bytes are written to, or read from,
//   consecutive addresses. X/Y/Z samples are snapshotted when cs falls so that
//   a multi-byte read returns one coherent sample set.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, cs, mosi      SPI inputs, asynchronous to clk (cs active-low)
//   miso, miso_oe       serial data out and pad output enable
//   x_data/y_data/z_data live sample inputs
//   power_ctl           POWER_CTL register (address 0x2D)
//   measure_en          power_ctl[1:0] == 2'b10
//   soft_rst, cmd_err   one-clock event pulses
//   busy                high while a frame is in progress
module spi_accel_slave #(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [7:0] SOFT_RST_KEY = 8'h52
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] x_data,
   input  logic [7:0] y_data,
   input  logic [7:0] z_data,
   output logic [7:0] power_ctl,
   output logic       measure_en,
   output logic       soft_rst,
   output logic       cmd_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RDATA  = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

   // Register map as seen by a read; write-only and unmapped addresses read 0.
   function automatic logic [7:0] read_reg(input logic [7:0] a, input logic [7:0] xs,
                                           input logic [7:0] ys, input logic [7:0] zs,
                                           input logic [7:0] pc);
      logic [7:0] v;
      case (a)
         8'h08:   v = xs;
         8'h09:   v = ys;
         8'h0A:   v = zs;
         8'h2D:   v = pc;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic       sclk_prev_q, cs_prev_q;
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_in_q, shift_in_d;
   logic [7:0] shift_out_q, shift_out_d;
   logic [7:0] addr_q, addr_d;
   logic       is_read_q, is_read_d;
   logic       first_q, first_d;
   logic [7:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d;
   logic [7:0] power_ctl_q, power_ctl_d;
   logic       measure_en_q, measure_en_d;
   logic       soft_rst_q, soft_rst_d;
   logic       cmd_err_q, cmd_err_d;
   logic       busy_q, busy_d;
   logic       miso_q, miso_d;

   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
   logic [7:0] rx_byte_s;

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s = ~sclk_s & sclk_prev_q;
   assign cs_rise_s   = cs_s & ~cs_prev_q;
   assign cs_fall_s   = ~cs_s & cs_prev_q;
   assign rx_byte_s   = {shift_in_q, mosi_s};

   // Synchronizer shift chains for the asynchronous SPI pins.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end

   // Frame FSM, shift registers, register file and event pulses.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      addr_d      = addr_q;
      is_read_d   = is_read_q;
      first_d     = first_q;
      x_sh_d      = x_sh_q;
      y_sh_d      = y_sh_q;
      z_sh_d      = z_sh_q;
      power_ctl_d = power_ctl_q;
      soft_rst_d  = 1'b0;
      cmd_err_d   = 1'b0;
      busy_d      = busy_q;

      if (state_q == ST_IDLE) begin
         bit_cnt_d = 3'd0;
         if (cs_fall_s) begin
            state_d = ST_CMD;
            busy_d  = 1'b1;
            x_sh_d  = x_data;
            y_sh_d  = y_data;
            z_sh_d  = z_data;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         if (sclk_rise_s) begin
            shift_in_d = rx_byte_s[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (state_q)
                  ST_CMD: begin
                     if (rx_byte_s == 8'h0A) begin
                        state_d   = ST_ADDR;
                        is_read_d = 1'b0;
                     end else if (rx_byte_s == 8'h0B) begin
                        state_d   = ST_ADDR;
                        is_read_d = 1'b1;
                     end else begin
                        state_d   = ST_IGNORE;
                        cmd_err_d = 1'b1;
                     end
                  end
                  ST_ADDR: begin
                     addr_d  = rx_byte_s;
                     first_d = 1'b1;
                     state_d = is_read_q ? ST_RDATA : ST_WDATA;
                  end
                  ST_WDATA: begin
                     addr_d = addr_q + 8'd1;
                     if (addr_q == 8'h2D) begin
                        power_ctl_d = rx_byte_s;
                     end else if ((addr_q == 8'h1F) && (rx_byte_s == SOFT_RST_KEY)) begin
                        soft_rst_d  = 1'b1;
                        power_ctl_d = 8'h00;
                     end else begin
                        power_ctl_d = power_ctl_q;
                     end
                  end
                  default: state_d = state_q;
               endcase
            end else begin
               state_d = state_q;
            end
         end else if (sclk_fall_s && (state_q == ST_RDATA)) begin
            // bit_cnt==0 on a fall means a byte boundary: load the next byte so
            // bit7 is already on miso before the following sclk rise.
            if (bit_cnt_q == 3'd0) begin
               if (first_q) begin
                  shift_out_d = read_reg(addr_q, x_sh_q, y_sh_q, z_sh_q, power_ctl_q);
                  first_d     = 1'b0;
               end else begin
                  shift_out_d = read_reg(addr_q + 8'd1, x_sh_q, y_sh_q, z_sh_q, power_ctl_q);
                  addr_d      = addr_q + 8'd1;
               end
            end else begin
               shift_out_d = {shift_out_q[6:0], 1'b0};
            end
         end else begin
            shift_out_d = shift_out_q;
         end

         // Evaluated after the byte logic so a byte ending in the same cycle still commits.
         if (cs_rise_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b0;
         end else begin
            busy_d    = busy_q;
         end
      end

      measure_en_d = (power_ctl_d[1:0] == 2'b10);
      miso_d       = (state_d == ST_RDATA) ? shift_out_d[7] : 1'b0;
   end

   // State register; cs synchronizer resets low so a cs already low at reset
   // release produces no fall and the frame waits for a fresh cs fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q  <= '0;
         cs_sync_q    <= '0;
         mosi_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b0;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_in_q   <= 7'd0;
         shift_out_q  <= 8'd0;
         addr_q       <= 8'd0;
         is_read_q    <= 1'b0;
         first_q      <= 1'b0;
         x_sh_q       <= 8'd0;
         y_sh_q       <= 8'd0;
         z_sh_q       <= 8'd0;
         power_ctl_q  <= 8'd0;
         measure_en_q <= 1'b0;
         soft_rst_q   <= 1'b0;
         cmd_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         miso_q       <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         cs_sync_q    <= cs_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_prev_q  <= sclk_s;
         cs_prev_q    <= cs_s;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_in_q   <= shift_in_d;
         shift_out_q  <= shift_out_d;
         addr_q       <= addr_d;
         is_read_q    <= is_read_d;
         first_q      <= first_d;
         x_sh_q       <= x_sh_d;
         y_sh_q       <= y_sh_d;
         z_sh_q       <= z_sh_d;
         power_ctl_q  <= power_ctl_d;
         measure_en_q <= measure_en_d;
         soft_rst_q   <= soft_rst_d;
         cmd_err_q    <= cmd_err_d;
         busy_q       <= busy_d;
         miso_q       <= miso_d;
      end
   end

   assign miso       = miso_q;
   assign miso_oe    = busy_q;
   assign power_ctl  = power_ctl_q;
   assign measure_en = measure_en_q;
   assign soft_rst   = soft_rst_q;
   assign cmd_err    = cmd_err_q;
   assign busy       = busy_q;

endmodule
